// File: rtl/hex_pkg.sv
// Shared constants and the leading-zero helper for the seven-segment scanner.
package hex_pkg;
  localparam int DIGITS_DEF = 8;
  localparam int DIV_DEF    = 50000;
  localparam int MAX_DIGITS = 16;

  localparam logic [MAX_DIGITS-1:0] AN_OFF = '1;

  // Digit i is blankable when it and every nibble above it are zero; digit 0 always shows.
  function automatic logic digit_blank(input logic [4*MAX_DIGITS-1:0] disp, input int unsigned i);
    return (i != 0) && ((disp >> (4*i)) == '0);
  endfunction
endpackage

// File: rtl/tick_gen.sv
// Slot prescaler: counts 0..DIV-1 and flags the last count of each slot.
module tick_gen
  import hex_pkg::*;
#(
  parameter int DIV = DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick  = (cnt_q == CW'(DIV-1));
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/hex_scan.sv
// 8-digit multiplexed display scanner with frame-synchronous value commit
// and optional leading-zero blanking.
module hex_scan
  import hex_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int DIV    = DIV_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   din,
  input  logic                  blank_lz,
  output logic                  ready,
  output logic [3:0]            nibble,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS-1);

  logic                    tick, boundary, blank;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*DIGITS-1:0]     shadow_q, shadow_d, disp_q, disp_d;
  logic                    pending_q, pending_d;
  logic [3:0]              nibble_q, nibble_d;
  logic [DIGITS-1:0]       an_q, an_d;
  logic                    ft_q, ft_d;
  logic [4*MAX_DIGITS-1:0] disp_ext;

  tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  always_comb begin
    boundary  = tick && (idx_q == LAST);
    idx_d     = idx_q;
    shadow_d  = load ? din : shadow_q;
    pending_d = pending_q;
    disp_d    = disp_q;
    nibble_d  = nibble_q;
    an_d      = an_q;
    ft_d      = boundary;

    if (tick) idx_d = boundary ? '0 : idx_q + 1'b1;

    // A load landing on the boundary bypasses the shadow so it is shown this frame.
    if (boundary) begin
      pending_d = 1'b0;
      if (load)           disp_d = din;
      else if (pending_q) disp_d = shadow_q;
    end else if (load) begin
      pending_d = 1'b1;
    end

    disp_ext                = '0;
    disp_ext[4*DIGITS-1:0]  = disp_d;
    blank = blank_lz && digit_blank(disp_ext, 32'(idx_d));

    if (tick) begin
      nibble_d = disp_d[4*idx_d +: 4];
      an_d     = blank ? AN_OFF[DIGITS-1:0] : ~(DIGITS'(1) << idx_d);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q     <= LAST;
      shadow_q  <= '0;
      disp_q    <= '0;
      pending_q <= 1'b0;
      nibble_q  <= '0;
      an_q      <= AN_OFF[DIGITS-1:0];
      ft_q      <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      nibble_q  <= nibble_d;
      an_q      <= an_d;
      ft_q      <= ft_d;
    end
  end

  assign ready      = ~pending_q;
  assign nibble     = nibble_q;
  assign an         = an_q;
  assign frame_tick = ft_q;
endmodule

// File: tb/tb_hex_scan.sv
// Randomized bench for hex_scan against a cycle-count based display model.
module tb_hex_scan;
  localparam int DIGITS = 8;
  localparam int DIV    = 4;
  localparam int FRAME  = DIGITS*DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [31:0] din = '0;
  logic        blank_lz = 1'b0;
  logic        ready;
  logic [3:0]  nibble;
  logic [7:0]  an;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  // Model: edge index since reset release, latest loaded value, commit state.
  int          k;
  logic [31:0] latest, disp_m;
  bit          since;
  logic [3:0]  nib_m;
  logic [7:0]  an_m;
  bit          ft_m;

  hex_scan #(.DIGITS(DIGITS), .DIV(DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .din        (din),
    .blank_lz   (blank_lz),
    .ready      (ready),
    .nibble     (nibble),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_tick(input int e);
    return (e % DIV) == DIV-1;
  endfunction

  function automatic int slot_of(input int e);
    return ((e+1)/DIV - 1) % DIGITS;
  endfunction

  task automatic model_reset();
    k = 0; since = 0; latest = '0; disp_m = '0;
    nib_m = '0; an_m = 8'hFF; ft_m = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ready"}, 32'(ready), 32'(!since));
    chk({tag, ".nibble"}, 32'(nibble), 32'(nib_m));
    chk({tag, ".an"}, 32'(an), 32'(an_m));
    chk({tag, ".ftick"}, 32'(frame_tick), 32'(ft_m));
  endtask

  // Called at #1 after a posedge; drives one edge and checks the result.
  task automatic step(input bit ld, input logic [31:0] d, input string tag);
    bit tk, bnd, blank;
    int s;
    load = ld;
    din  = d;
    @(posedge clk);
    tk  = is_tick(k);
    s   = slot_of(k);
    bnd = tk && (s == 0);
    if (ld) begin latest = d; since = 1; end
    ft_m = bnd;
    if (bnd) begin
      if (since) disp_m = latest;
      since = 0;
    end
    if (tk) begin
      nib_m = disp_m[4*s +: 4];
      blank = blank_lz && (s > 0) && ((disp_m >> (4*s)) == 0);
      an_m  = blank ? 8'hFF : ~(8'h01 << s);
    end
    k++;
    #1;
    check_all(tag);
    load = 1'b0;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(0, '0, tag);
  endtask

  // Asynchronous reset assertion mid-slot; outputs must clear without a clock edge.
  task automatic do_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    chk({tag, ".rst_ready"}, 32'(ready), 32'd1);
    chk({tag, ".rst_an"}, 32'(an), 32'hFF);
    chk({tag, ".rst_nibble"}, 32'(nibble), 32'd0);
    chk({tag, ".rst_ftick"}, 32'(frame_tick), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    do_reset("t0");

    // Test 1: load at cycle 1, full frame walk.
    step(0, '0, "t1");
    step(1, 32'h1234_ABCD, "t1");
    chk("t1.ready_low", 32'(ready), 32'd0);
    idle(3*FRAME, "t1");

    // Test 2: leading-zero blanking.
    blank_lz = 1'b1;
    step(1, 32'h0000_00F0, "t2");
    idle(2*FRAME, "t2");
    step(1, 32'h0, "t2");
    idle(2*FRAME, "t2");
    blank_lz = 1'b0;

    // Test 3: back-to-back loads mid-frame; latest wins.
    while ((k % FRAME) != 14) step(0, '0, "t3");
    step(1, 32'h1111_1111, "t3");
    step(1, 32'h2222_2222, "t3");
    idle(2*FRAME, "t3");

    // Test 4: load on the exact wrap edge.
    while (!(is_tick(k) && slot_of(k) == 0)) step(0, '0, "t4");
    step(1, 32'hDEAD_BEEF, "t4");
    chk("t4.nibble_now", 32'(nibble), 32'hF);
    step(0, '0, "t4");
    chk("t4.ready_hold", 32'(ready), 32'd1);
    idle(FRAME, "t4");

    // Test 5: reset mid-slot with a pending value.
    while ((k % FRAME) != 9) step(0, '0, "t5");
    step(1, 32'h5555_AAAA, "t5");
    step(0, '0, "t5");
    do_reset("t5");
    idle(2*FRAME, "t5");

    // Test 6: three quiet frames after a committed value.
    step(1, 32'h0BAD_F00D, "t6");
    idle(4*FRAME, "t6");

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      logic [31:0] d;
      if ((i % 64) == 0) blank_lz = 1'($urandom_range(0, 1));
      d = $urandom() >> (4 * $urandom_range(0, 8));
      if ($urandom_range(0, 7) == 0) step(1, d, "rnd");
      else                           step(0, '0, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
